// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs MULT/DIV over a fixed
// busy window and commits the precomputed result when the window closes.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic        state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_valid;

  logic        op_valid;
  logic        issue;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_sdiv;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign op_valid = (mdu_op >= OP_MULT) && (mdu_op <= OP_MTLO);
  assign issue    = op_valid && !req && (state_reg == STATE_IDLE);

  assign prod_s = 64'($signed(rs_val)) * 64'($signed(rt_val));
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // without relying on signed-overflow behaviour of the divider.
  always_comb begin
    is_sdiv = (mdu_op == OP_DIV);
    dvd_neg = is_sdiv && rs_val[31];
    dvs_neg = is_sdiv && rt_val[31];
    div_a   = dvd_neg ? (32'd0 - rs_val) : rs_val;
    div_b   = dvs_neg ? (32'd0 - rt_val) : rt_val;
    q_mag   = 32'd0;
    r_mag   = 32'd0;
    if (div_b != 32'd0) begin
      q_mag = div_a / div_b;
      r_mag = div_a % div_b;
    end
    div_q = (dvd_neg ^ dvs_neg) ? (32'd0 - q_mag) : q_mag;
    div_r = dvd_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= STATE_IDLE;
      cnt_reg    <= 4'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
    end else begin
      case (state_reg)
        STATE_IDLE: begin
          if (issue) begin
            case (mdu_op)
              OP_MTHI: hi_reg <= rs_val;
              OP_MTLO: lo_reg <= rs_val;
              OP_MULT: begin
                pend_hi    <= prod_s[63:32];
                pend_lo    <= prod_s[31:0];
                pend_valid <= 1'b1;
                cnt_reg    <= MULT_N;
                state_reg  <= STATE_RUN;
              end
              OP_MULTU: begin
                pend_hi    <= prod_u[63:32];
                pend_lo    <= prod_u[31:0];
                pend_valid <= 1'b1;
                cnt_reg    <= MULT_N;
                state_reg  <= STATE_RUN;
              end
              OP_DIV, OP_DIVU: begin
                // A zero divisor still occupies the full window but commits nothing.
                pend_hi    <= div_r;
                pend_lo    <= div_q;
                pend_valid <= (rt_val != 32'd0);
                cnt_reg    <= DIV_N;
                state_reg  <= STATE_RUN;
              end
              default: ;
            endcase
          end
        end
        default: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg  <= STATE_IDLE;
            pend_valid <= 1'b0;
            if (pend_valid) begin
              hi_reg <= pend_hi;
              lo_reg <= pend_lo;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state_reg == STATE_RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the P7 five-stage MIPS pipeline with exception/interrupt support. It consumes the instruction and operands latched by the ID/EX register, then runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. It also executes MTHI/MTLO and holds the architectural HI/LO registers. It exports `busy` so hazard control can stall MD-class instructions, and it honours `req` so that a flushed E-stage instruction never changes HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  reset; one clock, asynchronous, active-high.
- `req`  in  1  exception/interrupt flush; the E-stage instruction in this cycle is cancelled.
- `mdu_op`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `rs_val`  in  32  forwarded rs operand; dividend / multiplicand / MTHI / MTLO source.
- `rt_val`  in  32  forwarded rt operand; divisor / multiplier.
- `busy`  out  1  multi-cycle operation in flight.
- `hi`  out  32  HI register, registered.
- `lo`  out  32  LO register, registered.

## Operation
- An issue is sampled at a `clk` rising edge when all three hold: `mdu_op` is in 1..6, `req`=0 and `busy`=0.
- Any op presented while `busy`=1 is ignored. Hazard control guarantees this does not happen; the bench flags it as an error.
- Any op presented with `req`=1 is ignored. HI/LO, `busy` and the counter are unchanged.
- `req` never affects an op already in flight. That instruction has passed E and is committed, so the operation completes normally.
- MTHI/MTLO: `hi` or `lo` is loaded with `rs_val` at the issue edge. `busy` is not asserted.
- MULT/MULTU/DIV/DIVU: at the issue edge the unit computes the result into internal `pend_hi`/`pend_lo` registers and loads a 4-bit down-counter with MULT_CYCLES or DIV_CYCLES. `busy` is set at the same edge.
- States: IDLE (counter=0, `busy`=0) and RUN (counter>0, `busy`=1).
  - IDLE→RUN on a multi-cycle issue.
  - In RUN, the counter decrements every edge.
  - On the edge where the counter goes 1→0: `hi`←`pend_hi`, `lo`←`pend_lo`, `busy`←0, state returns to IDLE.
- MULT: signed 32×32→64; `hi` = product[63:32], `lo` = product[31:0]. MULTU: the same, unsigned.
- DIV: signed. `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divisor 0, for DIV or DIVU: `busy` runs the full DIV_CYCLES, then `hi`/`lo` keep their prior values.
- `reset`, including mid-operation: asynchronously clears `hi`, `lo`, `pend_hi`, `pend_lo`, the counter and `busy` to 0. The in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0.
- MTHI/MTLO: new value visible in the cycle after the issue edge. Latency 1, no busy period.
- Multi-cycle op issued at edge T0:
  - `busy`=1 from just after T0 to just after T0+N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
  - New `hi`/`lo` are visible from just after T0+N, in the same cycle `busy` falls.
- A new op may issue at edge T0+N+1, the first edge sampled with `busy`=0.
- Hazard control stalls an MD-class instruction in D when `busy`=1 or an MD multi-cycle op is being issued in E. This combination lives outside the block.
- `hi`/`lo` are purely registered outputs: no combinational path from the inputs.

## Test plan
- Reset then MULT with `rs_val`=0xFFFFFFFE (−2) and `rt_val`=3 → `busy` is high for exactly 5 cycles, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 5 busy cycles `hi`=0xFFFFFFFE, `lo`=0x00000001. DIVU 7/2 → after 10 cycles `lo`=3, `hi`=1.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIV 5/0 → 10 busy cycles, then `hi`/`lo` unchanged.
- MTHI 0x12345678 with `req`=1 → `hi` unchanged, `busy`=0. The same op with `req`=0 → `hi`=0x12345678 one cycle later, `busy` stays 0.
- DIVU issued, then `req`=1 pulsed on the third busy cycle → the op still completes at cycle 10 with the correct result. MULT presented while `busy`=1 → ignored, and the error is flagged.
- `reset` asserted asynchronously, mid-cycle, during cycle 3 of a DIV → `busy`, `hi` and `lo` go to 0 immediately. After reset is released, MTLO 0xA5A5A5A5 gives `lo`=0xA5A5A5A5.
